// File: rtl/tile_field_pkg.sv
// Shared types and colour constants for the tile field renderer.
// Screen modes, 4:4:4 RGB pixel type and the fixed colour set.
package tile_field_pkg;

   typedef enum logic [1:0] {
      START = 2'd0,
      PLAY  = 2'd1,
      FLASH = 2'd2,
      OVER  = 2'd3
   } mode_e;

   typedef struct packed {
      logic [3:0] r;
      logic [3:0] g;
      logic [3:0] b;
   } rgb444_t;

   localparam rgb444_t C_BG       = 12'h104;
   localparam rgb444_t C_FIELD_BG = 12'h007;
   localparam rgb444_t C_OUTLINE  = 12'h08F;
   localparam rgb444_t C_GRIDLINE = 12'h02F;
   localparam rgb444_t C_FLASH    = 12'hFFF;
   localparam rgb444_t C_GHOST    = 12'h888;

endpackage

// File: rtl/tile_palette_rom.sv
// Combinational tile palette: cell index -> 4:4:4 colour, index 0 is the empty field.
module tile_palette_rom
   import tile_field_pkg::*;
#(
   parameter int unsigned IDX_W = 3
) (
   input  logic [IDX_W-1:0] idx_i,
   output rgb444_t          rgb_o
);

   logic [31:0] idx_ext;

   always_comb begin
      idx_ext = 32'(idx_i);
      rgb_o   = C_FIELD_BG;
      case (idx_ext)
         32'd0:   rgb_o = C_FIELD_BG;
         32'd1:   rgb_o = 12'h0FF;
         32'd2:   rgb_o = 12'h00F;
         32'd3:   rgb_o = 12'hF80;
         32'd4:   rgb_o = 12'hFF0;
         32'd5:   rgb_o = 12'h0F0;
         32'd6:   rgb_o = 12'hF0F;
         32'd7:   rgb_o = 12'hF00;
         default: rgb_o = C_GHOST;
      endcase
   end

endmodule

// File: rtl/tile_field_renderer.sv
// Two-stage tile field renderer with screen-mode FSM (START/PLAY/FLASH/OVER).
// Define GRID_LINES_EN to draw cell outlines over tiles in PLAY/FLASH/OVER.
module tile_field_renderer
   import tile_field_pkg::*;
#(
   parameter int unsigned GRID_ROWS    = 20,
   parameter int unsigned GRID_COLS    = 10,
   parameter int unsigned CELL_PX      = 24,
   parameter int unsigned ORIGIN_X     = 100,
   parameter int unsigned ORIGIN_Y     = 0,
   parameter int unsigned IDX_W        = 3,
   parameter int unsigned FLASH_FRAMES = 24,
   parameter int unsigned FLASH_SHIFT  = 2
) (
   input  logic                                 Clk,
   input  logic                                 Reset_n,
   input  logic [9:0]                           DrawX,
   input  logic [9:0]                           DrawY,
   input  logic                                 vde,
   input  logic                                 frame_start,
   input  logic [GRID_ROWS*GRID_COLS*IDX_W-1:0] grid_flat,
   input  logic [GRID_ROWS-1:0]                 clear_rows,
   input  logic                                 start_req,
   input  logic                                 game_over,
   output logic [3:0]                           Red,
   output logic [3:0]                           Green,
   output logic [3:0]                           Blue,
   output logic                                 pix_valid,
   output logic                                 flash_done,
   output logic [1:0]                           mode
);

   localparam int unsigned ROW_W  = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
   localparam int unsigned COL_W  = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
   localparam int unsigned SUB_W  = $clog2(CELL_PX);
   localparam int unsigned CNT_C  = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int unsigned CNT_W  = (CNT_C > FLASH_SHIFT) ? CNT_C : FLASH_SHIFT + 1;

   localparam logic [9:0]       X_LO     = 10'(ORIGIN_X);
   localparam logic [9:0]       X_HI     = 10'(ORIGIN_X + GRID_COLS * CELL_PX);
   localparam logic [9:0]       X_OL     = 10'(ORIGIN_X - 1);
   localparam logic [9:0]       Y_LO     = 10'(ORIGIN_Y);
   localparam logic [9:0]       Y_HI     = 10'(ORIGIN_Y + GRID_ROWS * CELL_PX);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_FRAMES - 1);

   // Stage 1: cell counters double as the stage-1 pipeline registers.
   logic [COL_W-1:0] col_q, col_d;
   logic [SUB_W-1:0] csub_q, csub_d;
   logic [ROW_W-1:0] row_q, row_d;
   logic [SUB_W-1:0] rsub_q, rsub_d;
   logic             vde1_q, infield1_q, outline1_q;
   logic             infield_d, outline_d, rows_in;

   always_comb begin
      col_d  = col_q;
      csub_d = csub_q;
      if (DrawX == X_LO) begin
         col_d  = '0;
         csub_d = '0;
      end else if (csub_q == SUB_LAST) begin
         csub_d = '0;
         col_d  = col_q + COL_W'(1);
      end else begin
         csub_d = csub_q + SUB_W'(1);
      end

      row_d  = row_q;
      rsub_d = rsub_q;
      if (DrawX == '0) begin
         if (DrawY == Y_LO) begin
            row_d  = '0;
            rsub_d = '0;
         end else if (rsub_q == SUB_LAST) begin
            rsub_d = '0;
            row_d  = row_q + ROW_W'(1);
         end else begin
            rsub_d = rsub_q + SUB_W'(1);
         end
      end

      rows_in   = (DrawY >= Y_LO) && (DrawY < Y_HI);
      infield_d = rows_in && (DrawX >= X_LO) && (DrawX < X_HI);
      outline_d = rows_in && ((DrawX == X_OL) || (DrawX == X_HI));
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         col_q      <= '0;
         csub_q     <= '0;
         row_q      <= '0;
         rsub_q     <= '0;
         vde1_q     <= 1'b0;
         infield1_q <= 1'b0;
         outline1_q <= 1'b0;
      end else begin
         col_q      <= col_d;
         csub_q     <= csub_d;
         row_q      <= row_d;
         rsub_q     <= rsub_d;
         vde1_q     <= vde;
         infield1_q <= infield_d;
         outline1_q <= outline_d;
      end
   end

   // Screen-mode FSM
   mode_e                state_q, state_d;
   logic [GRID_ROWS-1:0] mask_q, mask_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 done_q, done_d;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      if (game_over) begin
         state_d = OVER;
         mask_d  = '0;
         cnt_d   = '0;
      end else begin
         case (state_q)
            START: if (start_req) state_d = PLAY;
            PLAY: begin
               if (frame_start && (|clear_rows)) begin
                  state_d = FLASH;
                  mask_d  = clear_rows;
                  cnt_d   = '0;
               end
            end
            FLASH: begin
               if (frame_start) begin
                  if (cnt_q == CNT_LAST) begin
                     state_d = PLAY;
                     mask_d  = '0;
                     cnt_d   = '0;
                     done_d  = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CNT_W'(1);
                  end
               end
            end
            OVER:    if (start_req) state_d = START;
            default: state_d = START;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= START;
         mask_q  <= '0;
         cnt_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
      end
   end

   // Stage 2: constant-index loops keep the grid mux in range for any counter value.
   logic [IDX_W-1:0] idx;
   logic             mask_hit;
   rgb444_t          pal;
   rgb444_t          rgb_d, rgb_q;
   logic             valid_q;

   always_comb begin
      idx      = '0;
      mask_hit = 1'b0;
      for (int unsigned r = 0; r < GRID_ROWS; r++) begin
         if (row_q == ROW_W'(r)) begin
            mask_hit = mask_q[r];
            for (int unsigned c = 0; c < GRID_COLS; c++) begin
               if (col_q == COL_W'(c)) idx = grid_flat[(r*GRID_COLS+c)*IDX_W +: IDX_W];
            end
         end
      end
   end

   tile_palette_rom #(
      .IDX_W (IDX_W)
   ) u_palette (
      .idx_i (idx),
      .rgb_o (pal)
   );

   always_comb begin
      rgb_d = C_BG;
      if (!vde1_q) begin
         rgb_d = '0;
      end else if (outline1_q) begin
         rgb_d = C_OUTLINE;
      end else if (infield1_q) begin
         case (state_q)
            START:   rgb_d = C_FIELD_BG;
            PLAY:    rgb_d = pal;
            FLASH:   rgb_d = (mask_hit && !cnt_q[FLASH_SHIFT]) ? C_FLASH : pal;
            OVER:    rgb_d = (idx != '0) ? C_GHOST : C_FIELD_BG;
            default: rgb_d = C_BG;
         endcase
`ifdef GRID_LINES_EN
         if ((state_q != START) && ((csub_q == '0) || (rsub_q == '0))) rgb_d = C_GRIDLINE;
`endif
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         rgb_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         rgb_q   <= rgb_d;
         valid_q <= vde1_q;
      end
   end

   assign Red        = rgb_q.r;
   assign Green      = rgb_q.g;
   assign Blue       = rgb_q.b;
   assign pix_valid  = valid_q;
   assign flash_done = done_q;
   assign mode       = state_q;

endmodule

// File: tb/tb_tile_field_renderer.sv
// Scoreboard bench for tile_field_renderer: directed pixels, queued expected colours.
module tb_tile_field_renderer;
   import tile_field_pkg::*;

   localparam logic [11:0] E_BG   = 12'h104;
   localparam logic [11:0] E_FBG  = 12'h007;
   localparam logic [11:0] E_OL   = 12'h08F;
   localparam logic [11:0] E_WH   = 12'hFFF;
   localparam logic [11:0] E_GH   = 12'h888;
   localparam logic [11:0] E_PAL2 = 12'h00F;
   localparam logic [11:0] E_PAL3 = 12'hF80;
   localparam logic [11:0] E_PAL5 = 12'h0F0;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [9:0]  DrawX, DrawY;
   logic        vde, frame_start, start_req, game_over;
   logic [599:0] grid;
   logic [19:0] clear_rows;
   logic [3:0]  Red, Green, Blue;
   logic        pix_valid, flash_done;
   logic [1:0]  mode;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;

   logic [11:0] q_rgb[$];
   int          q_cyc[$];
   string       q_nm[$];

   tile_field_renderer #(
      .GRID_ROWS (20),
      .GRID_COLS (10),
      .CELL_PX   (24),
      .ORIGIN_X  (100),
      .ORIGIN_Y  (0)
   ) dut (
      .Clk         (clk),
      .Reset_n     (rst_n),
      .DrawX       (DrawX),
      .DrawY       (DrawY),
      .vde         (vde),
      .frame_start (frame_start),
      .grid_flat   (grid),
      .clear_rows  (clear_rows),
      .start_req   (start_req),
      .game_over   (game_over),
      .Red         (Red),
      .Green       (Green),
      .Blue        (Blue),
      .pix_valid   (pix_valid),
      .flash_done  (flash_done),
      .mode        (mode)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every valid output pixel pops one expectation; latency must be 2.
   always @(negedge clk) begin
      if (flash_done) done_cnt++;
      if (rst_n && pix_valid) begin
         checks++;
         if (q_rgb.size() == 0) begin
            errors++;
            $display("FAIL pix_unexpected: got rgb=%h, none expected", {Red, Green, Blue});
         end else begin
            logic [11:0] e;
            int          c;
            string       nm;
            e  = q_rgb.pop_front();
            c  = q_cyc.pop_front();
            nm = q_nm.pop_front();
            if (({Red, Green, Blue} !== e) || (cyc - c != 2)) begin
               errors++;
               $display("FAIL pix_%s: got rgb=%h lat=%0d, want rgb=%h lat=2", nm, {Red, Green, Blue}, cyc - c, e);
            end
         end
      end
   end

   initial begin
      #50000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", nm, got, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int x, input int y);
      DrawX = 10'(x);
      DrawY = 10'(y);
      vde   = 1'b0;
      step();
   endtask

   task automatic px(input int x, input int y, input logic [11:0] e, input string nm);
      DrawX = 10'(x);
      DrawY = 10'(y);
      vde   = 1'b1;
      q_rgb.push_back(e);
      q_cyc.push_back(cyc);
      q_nm.push_back($sformatf("%s_x%0d_y%0d", nm, x, y));
      step();
   endtask

   task automatic frame(input logic [19:0] cr);
      clear_rows  = cr;
      frame_start = 1'b1;
      idle(0, 0);
      frame_start = 1'b0;
   endtask

   task automatic set_cell(input int r, input int c, input logic [2:0] v);
      grid[(r*10+c)*3 +: 3] = v;
   endtask

   // Row 0 then row 19 (DrawY 456) after walking the line counter down.
   task automatic frame_body(input logic [11:0] r0, input logic [11:0] r19a,
                             input logic [11:0] r19b, input string nm);
      px(100, 0, r0, {nm, "_r0"});
      px(101, 0, r0, {nm, "_r0"});
      for (int yy = 1; yy <= 456; yy++) idle(0, yy);
      for (int x = 100; x <= 123; x++) px(x, 456, r19a, {nm, "_r19c0"});
      px(124, 456, r19b, {nm, "_r19c1"});
      px(125, 456, r19b, {nm, "_r19c1"});
      idle(700, 0);
      idle(700, 0);
   endtask

   initial begin
      rst_n = 1'b0;
      DrawX = 10'd110;
      DrawY = 10'd5;
      vde = 1'b1;
      frame_start = 1'b0;
      start_req = 1'b0;
      game_over = 1'b0;
      clear_rows = '0;
      grid = '0;
      set_cell(0, 0, 3'd3);
      set_cell(0, 1, 3'd5);
      set_cell(19, 0, 3'd2);
      repeat (3) step();
      chk("reset_rgb", int'({Red, Green, Blue}), 0);
      chk("reset_valid", int'(pix_valid), 0);
      chk("reset_mode", int'(mode), int'(START));
      chk("reset_done", int'(flash_done), 0);
      rst_n = 1'b1;
      idle(0, 0);
      chk("start_mode", int'(mode), int'(START));

      px(99, 0, E_OL, "start_outline");
      px(100, 0, E_FBG, "start_field");
      px(101, 0, E_FBG, "start_field");
      idle(700, 0);
      idle(700, 0);

      start_req = 1'b1;
      idle(700, 0);
      start_req = 1'b0;
      chk("mode_play", int'(mode), int'(PLAY));

      for (int yy = 0; yy <= 5; yy++) idle(0, yy);
      px(99, 5, E_OL, "play_outline_l");
      for (int x = 100; x <= 123; x++) px(x, 5, E_PAL3, "play_cell00");
      px(124, 5, E_PAL5, "play_cell01");
      px(125, 5, E_PAL5, "play_cell01");
      idle(700, 0);
      idle(700, 0);
      px(340, 5, E_OL, "play_outline_r");
      px(341, 5, E_BG, "play_bg_right");
      px(400, 300, E_BG, "play_bg");
      idle(110, 5);
      idle(700, 0);
      chk("blank_valid", int'(pix_valid), 0);
      chk("blank_rgb", int'({Red, Green, Blue}), 0);
      idle(700, 0);

      // Row 19 flash; row 0 requests during the flash must be ignored.
      frame(20'h80000);
      chk("mode_flash", int'(mode), int'(FLASH));
      for (int f = 0; f < 24; f++) begin
         if (f > 0) frame(20'h00001);
         if (((f >> 2) & 1) == 0) frame_body(E_PAL3, E_WH, E_WH, $sformatf("flash%0d", f));
         else frame_body(E_PAL3, E_PAL2, E_FBG, $sformatf("flash%0d", f));
      end
      chk("done_before_end", done_cnt, 0);
      frame(20'h00001);
      chk("flash_done_pulse", int'(flash_done), 1);
      chk("mode_after_flash", int'(mode), int'(PLAY));
      clear_rows = '0;
      idle(700, 0);
      chk("flash_done_clear", int'(flash_done), 0);
      frame_body(E_PAL3, E_PAL2, E_FBG, "post_flash");
      chk("mode_still_play", int'(mode), int'(PLAY));

      // Game over in flash frame 10.
      frame(20'h80000);
      for (int k = 1; k <= 10; k++) frame(20'h0);
      chk("mode_flash_again", int'(mode), int'(FLASH));
      game_over = 1'b1;
      idle(700, 0);
      chk("mode_over", int'(mode), int'(OVER));
      chk("over_no_done", int'(flash_done), 0);
      for (int k = 0; k < 14; k++) frame(20'h0);
      chk("done_count", done_cnt, 1);
      idle(0, 0);
      for (int x = 100; x <= 147; x++) px(x, 0, E_GH, "over_filled");
      px(148, 0, E_FBG, "over_empty");
      px(149, 0, E_FBG, "over_empty");
      idle(700, 0);
      idle(700, 0);

      start_req = 1'b1;
      idle(700, 0);
      chk("over_hold", int'(mode), int'(OVER));
      game_over = 1'b0;
      idle(700, 0);
      start_req = 1'b0;
      chk("mode_restart", int'(mode), int'(START));
      idle(700, 0);
      chk("mode_start_hold", int'(mode), int'(START));

      repeat (4) idle(700, 0);
      chk("queue_drained", q_rgb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
